pdp8_mem_arbiter: RTL

- Shares the single-port PDP-8 main memory between three requesters: the instruction decoder's fetch port, the execution unit's read port and the execution unit's write port.
- Sits between instr_decode / instr_exec and memory_pdp.
- Serialises accesses through a small FSM and routes read data back to the owning requester.
- Uses fixed priority with a fetch anti-starvation override.

---
 rtl/pdp8_mem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pdp8_mem_arbiter.sv
// Arbitrates the single-port PDP-8 main memory between fetch, exec read and exec write.
// Fixed priority (write > read > fetch) with a forced fetch win after MAX_WAIT lost decisions.
module pdp8_mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int RD_LAT     = 1,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic                  ifu_gnt,
    output logic                  ifu_rd_valid,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic                  exec_rd_gnt,
    output logic                  exec_rd_valid,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  exec_wr_gnt,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  arb_busy
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(RD_LAT + 1);

    // state  | meaning
    // IDLE   | arbitrate over requests sampled this cycle
    // ACCESS | mem_en strobe and grant pulse to the winner
    // WAIT   | RD_LAT-cycle read latency, capture on last cycle
    // RESP   | rd_valid pulse to the owner
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_IFU, OWN_RD, OWN_WR} owner_t;

    state_t          state, state_d;
    owner_t          owner, owner_d;
    logic [LW-1:0]   wait_cnt, wait_d;
    logic [CW-1:0]   starve_cnt, starve_d;
    logic            ifu_win, exec_win;

    logic                  ifu_gnt_d, exec_rd_gnt_d, exec_wr_gnt_d;
    logic                  ifu_rd_valid_d, exec_rd_valid_d;
    logic [DATA_WIDTH-1:0] ifu_rd_data_d, exec_rd_data_d;
    logic                  mem_en_d, mem_we_d, arb_busy_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;

    // Outputs are computed one cycle early so that every port is a flop.
    always_comb begin
        state_d         = state;
        owner_d         = owner;
        wait_d          = wait_cnt;
        starve_d        = starve_cnt;
        ifu_gnt_d       = 1'b0;
        exec_rd_gnt_d   = 1'b0;
        exec_wr_gnt_d   = 1'b0;
        ifu_rd_valid_d  = 1'b0;
        exec_rd_valid_d = 1'b0;
        ifu_rd_data_d   = ifu_rd_data;
        exec_rd_data_d  = exec_rd_data;
        mem_en_d        = 1'b0;
        mem_we_d        = 1'b0;
        mem_addr_d      = '0;
        mem_wdata_d     = '0;
        ifu_win  = ifu_rd_req && ((starve_cnt == CW'(MAX_WAIT)) || !(exec_wr_req || exec_rd_req));
        exec_win = !ifu_win && (exec_wr_req || exec_rd_req);

        case (state)
            S_IDLE: begin
                if (ifu_win) begin
                    state_d    = S_ACCESS;
                    owner_d    = OWN_IFU;
                    ifu_gnt_d  = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = ifu_rd_addr;
                    starve_d   = '0;
                end else if (exec_wr_req) begin
                    state_d       = S_ACCESS;
                    owner_d       = OWN_WR;
                    exec_wr_gnt_d = 1'b1;
                    mem_en_d      = 1'b1;
                    mem_we_d      = 1'b1;
                    mem_addr_d    = exec_wr_addr;
                    mem_wdata_d   = exec_wr_data;
                end else if (exec_rd_req) begin
                    state_d       = S_ACCESS;
                    owner_d       = OWN_RD;
                    exec_rd_gnt_d = 1'b1;
                    mem_en_d      = 1'b1;
                    mem_addr_d    = exec_rd_addr;
                end
                if (exec_win && ifu_rd_req && (starve_cnt != CW'(MAX_WAIT)))
                    starve_d = starve_cnt + CW'(1);
            end
            S_ACCESS: begin
                state_d = (owner == OWN_WR) ? S_IDLE : S_WAIT;
                wait_d  = LW'(RD_LAT - 1);
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = S_RESP;
                    if (owner == OWN_IFU) begin
                        ifu_rd_data_d  = mem_rdata;
                        ifu_rd_valid_d = 1'b1;
                    end else begin
                        exec_rd_data_d  = mem_rdata;
                        exec_rd_valid_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_cnt - LW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        arb_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            owner         <= OWN_IFU;
            wait_cnt      <= '0;
            starve_cnt    <= '0;
            ifu_gnt       <= 1'b0;
            exec_rd_gnt   <= 1'b0;
            exec_wr_gnt   <= 1'b0;
            ifu_rd_valid  <= 1'b0;
            exec_rd_valid <= 1'b0;
            ifu_rd_data   <= '0;
            exec_rd_data  <= '0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            arb_busy      <= 1'b0;
        end else begin
            state         <= state_d;
            owner         <= owner_d;
            wait_cnt      <= wait_d;
            starve_cnt    <= starve_d;
            ifu_gnt       <= ifu_gnt_d;
            exec_rd_gnt   <= exec_rd_gnt_d;
            exec_wr_gnt   <= exec_wr_gnt_d;
            ifu_rd_valid  <= ifu_rd_valid_d;
            exec_rd_valid <= exec_rd_valid_d;
            ifu_rd_data   <= ifu_rd_data_d;
            exec_rd_data  <= exec_rd_data_d;
            mem_en        <= mem_en_d;
            mem_we        <= mem_we_d;
            mem_addr      <= mem_addr_d;
            mem_wdata     <= mem_wdata_d;
            arb_busy      <= arb_busy_d;
        end
    end

endmodule
